rf_op_sequencer: RTL and testbench

- Initiator side of the 8-entry register file. Accepts one decoded instruction at a time over a valid/ready handshake.
- Drives the register-file read addresses, captures operands and computes the result internally. Issues the single write-back cycle (write enable, write address, write data).
- Sits between the decoder and the register file in the multi-cycle 8-bit datapath; single-issue, so no hazards are possible.

---
 rtl/rf_op_sequencer_if.sv | 46 ++++
 rtl/rf_op_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_rf_op_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_op_sequencer_if.sv
// Bus interfaces for rf_op_sequencer.
//   rf_op_seq_in_if : decoded-instruction valid/ready channel
//                     (master = decoder, slave = sequencer)
//                     in_valid, in_ready, in_op[2:0], in_rd, in_rs1, in_rs2, in_imm
//   rf_op_seq_rf_if : register-file access bus
//                     (master = sequencer, slave = register file)
//                     rf_read_addr1/2, rf_read_data1/2 (combinational read data),
//                     rf_write_enable, rf_write_addr, rf_write_data

interface rf_op_seq_in_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [DATA_W-1:0] in_imm;

    modport master (output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
                    input  in_ready);
    modport slave  (input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
                    output in_ready);
endinterface

interface rf_op_seq_rf_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [ADDR_W-1:0] rf_read_addr1;
    logic [ADDR_W-1:0] rf_read_addr2;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;

    modport master (output rf_read_addr1, rf_read_addr2,
                           rf_write_enable, rf_write_addr, rf_write_data,
                    input  rf_read_data1, rf_read_data2);
    modport slave  (input  rf_read_addr1, rf_read_addr2,
                           rf_write_enable, rf_write_addr, rf_write_data,
                    output rf_read_data1, rf_read_data2);
endinterface

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: register-file initiator for the multi-cycle 8-bit datapath.
// Accepts one decoded instruction, reads its operands, computes the result and
// issues a single write-back strobe. Sequence: IDLE -> FETCH -> EXEC -> WB -> IDLE.
//
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   in_bus      : instruction channel (slave side of rf_op_seq_in_if)
//   rf_bus      : register-file bus (master side of rf_op_seq_rf_if)
//   done        : one-cycle pulse when an instruction retires
//   result      : last computed result (held)
//   zero, carry : flags of the last computed result (held)
//   wb_err      : sticky write-back read-back mismatch
//
// Optional build macro RF_WB_CHECK_EN: adds a VERIFY state after WB that reads
// the destination back through port 1 and sets wb_err on mismatch. Without it,
// wb_err is constant 0 and done pulses in WB.

module rf_op_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    rf_op_seq_in_if.slave     in_bus,
    rf_op_seq_rf_if.master    rf_bus,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              wb_err
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned ALU_W = DATA_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_VERIFY = 3'd4
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_LI   = 3'd6,
        OP_ADDI = 3'd7
    } op_t;

    // Fields of the accepted instruction that outlive the handshake
    typedef struct packed {
        op_t               op;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] imm;
    } instr_t;

    state_t            state_q, state_d;
    instr_t            instr_q, instr_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] raddr1_q, raddr1_d;
    logic [ADDR_W-1:0] raddr2_q, raddr2_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
`ifdef RF_WB_CHECK_EN
    logic              wb_err_q, wb_err_d;
`endif

    logic [ALU_W-1:0]  alu_c;
    logic              carry_sel_c;
    logic              wen_c;

    // ALU: one extra bit so bit DATA_W is carry (add) or borrow (sub)
    always_comb begin
        alu_c       = '0;
        carry_sel_c = 1'b0;
        case (instr_q.op)
            OP_ADD: begin
                alu_c       = {1'b0, opa_q} + {1'b0, opb_q};
                carry_sel_c = 1'b1;
            end
            OP_SUB: begin
                alu_c       = {1'b0, opa_q} - {1'b0, opb_q};
                carry_sel_c = 1'b1;
            end
            OP_AND:  alu_c = {1'b0, opa_q & opb_q};
            OP_OR:   alu_c = {1'b0, opa_q | opb_q};
            OP_XOR:  alu_c = {1'b0, opa_q ^ opb_q};
            OP_LI:   alu_c = {1'b0, instr_q.imm};
            OP_ADDI: begin
                alu_c       = {1'b0, opa_q} + {1'b0, instr_q.imm};
                carry_sel_c = 1'b1;
            end
            default: alu_c = '0;
        endcase
    end

    // Register 0 is never written; NOP produces nothing to write
    assign wen_c = (instr_q.op != OP_NOP) && (instr_q.rd != '0);

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
`ifdef RF_WB_CHECK_EN
        wb_err_d = wb_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_bus.in_valid && in_ready_q) begin
                    instr_d.op  = op_t'(in_bus.in_op);
                    instr_d.rd  = in_bus.in_rd;
                    instr_d.imm = in_bus.in_imm;
                    raddr1_d    = in_bus.in_rs1;
                    raddr2_d    = in_bus.in_rs2;
                    state_d     = S_FETCH;
                end
            end

            S_FETCH: begin
                opa_d   = rf_bus.rf_read_data1;
                opb_d   = rf_bus.rf_read_data2;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                // NOP leaves result and flags untouched
                if (instr_q.op != OP_NOP) begin
                    result_d = alu_c[DATA_W-1:0];
                    zero_d   = (alu_c[DATA_W-1:0] == '0);
                    carry_d  = carry_sel_c & alu_c[DATA_W];
                end
                if (wen_c) begin
                    we_d    = 1'b1;
                    waddr_d = instr_q.rd;
                    wdata_d = alu_c[DATA_W-1:0];
                end
`ifdef RF_WB_CHECK_EN
                // Without a write there is nothing to verify, so retire in WB
                done_d  = ~wen_c;
`else
                done_d  = 1'b1;
`endif
                state_d = S_WB;
            end

            S_WB: begin
`ifdef RF_WB_CHECK_EN
                if (wen_c) begin
                    raddr1_d = instr_q.rd;
                    done_d   = 1'b1;
                    state_d  = S_VERIFY;
                end else begin
                    state_d  = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end

`ifdef RF_WB_CHECK_EN
            S_VERIFY: begin
                // Write committed at the end of WB; port 1 now shows rd
                if (rf_bus.rf_read_data1 != wdata_q) begin
                    wb_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
`endif

            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            in_ready_q <= 1'b1;
            raddr1_q   <= '0;
            raddr2_q   <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            carry_q    <= 1'b0;
`ifdef RF_WB_CHECK_EN
            wb_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            in_ready_q <= in_ready_d;
            raddr1_q   <= raddr1_d;
            raddr2_q   <= raddr2_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
`ifdef RF_WB_CHECK_EN
            wb_err_q   <= wb_err_d;
`endif
        end
    end

    assign in_bus.in_ready        = in_ready_q;
    assign rf_bus.rf_read_addr1   = raddr1_q;
    assign rf_bus.rf_read_addr2   = raddr2_q;
    assign rf_bus.rf_write_enable = we_q;
    assign rf_bus.rf_write_addr   = waddr_q;
    assign rf_bus.rf_write_data   = wdata_q;
    assign done                   = done_q;
    assign result                 = result_q;
    assign zero                   = zero_q;
    assign carry                  = carry_q;
`ifdef RF_WB_CHECK_EN
    assign wb_err                 = wb_err_q;
`else
    assign wb_err                 = 1'b0;
`endif

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Testbench for rf_op_sequencer: register-file model, instruction-level
// reference model, per-cycle output compare, directed and random stimulus.

module tb_rf_op_sequencer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
`ifdef RF_WB_CHECK_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    localparam int GAP      = FEAT ? 5 : 4;  // accept spacing for writing ops
    localparam int DONE_W   = FEAT ? 3 : 2;  // edges from accept to done, writing ops
    localparam int DONE_NW  = 2;             // edges from accept to done, no write

    logic clk   = 1'b0;
    logic reset = 1'b0;

    rf_op_seq_in_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ibus ();
    rf_op_seq_rf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rbus ();

    logic              done;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;
    logic              wb_err;

    rf_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .in_bus (ibus),
        .rf_bus (rbus),
        .done   (done),
        .result (result),
        .zero   (zero),
        .carry  (carry),
        .wb_err (wb_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: combinational read, write at clock edge; can drop r6 writes
    logic [7:0] rf_mem [8] = '{default: 8'h00};
    bit         drop_r6    = 1'b0;
    int         n_writes   = 0;
    logic [2:0] last_waddr = 3'd0;
    logic [7:0] last_wdata = 8'h00;

    assign rbus.rf_read_data1 = rf_mem[rbus.rf_read_addr1];
    assign rbus.rf_read_data2 = rf_mem[rbus.rf_read_addr2];

    always @(posedge clk) begin
        if (rbus.rf_write_enable === 1'b1) begin
            n_writes   <= n_writes + 1;
            last_waddr <= rbus.rf_write_addr;
            last_wdata <= rbus.rf_write_data;
            if (!(drop_r6 && rbus.rf_write_addr == 3'd6))
                rf_mem[rbus.rf_write_addr] <= rbus.rf_write_data;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at t=%0t: bound expired", name, $time);
    endtask

    // ---------------- reference model (per instruction) ----------------
    int  model_rf [8] = '{default: 0};
    bit  m_busy = 1'b0;
    int  m_age  = 0;
    int  m_op, m_rd, m_res;
    bit  m_cy, m_wen, m_verify, m_mis;
    bit  e_ready = 1'b1, e_we = 1'b0, e_done = 1'b0, e_zero = 1'b1, e_carry = 1'b0, e_wb_err = 1'b0;
    int  e_waddr = 0, e_wdata = 0, e_result = 0, e_raddr1 = 0, e_raddr2 = 0;

    task automatic model_step();
        int a, b, s;
        if (reset) begin
            m_busy = 0; m_age = 0;
            e_ready = 1; e_we = 0; e_done = 0; e_result = 0; e_zero = 1; e_carry = 0;
            e_wb_err = 0; e_waddr = 0; e_wdata = 0; e_raddr1 = 0; e_raddr2 = 0;
        end else if (!m_busy) begin
            if (ibus.in_valid) begin
                m_op = int'(ibus.in_op);
                m_rd = int'(ibus.in_rd);
                a    = model_rf[ibus.in_rs1];
                b    = (m_op == 7) ? int'(ibus.in_imm) : model_rf[ibus.in_rs2];
                m_cy = 0;
                case (m_op)
                    1, 7: begin s = a + b; m_res = s % 256; m_cy = (s > 255); end
                    2:    begin m_res = (a - b + 256) % 256; m_cy = (a < b); end
                    3:    m_res = a & b;
                    4:    m_res = a | b;
                    5:    m_res = a ^ b;
                    6:    m_res = int'(ibus.in_imm);
                    default: m_res = 0;
                endcase
                m_wen    = (m_op != 0) && (m_rd != 0);
                m_verify = FEAT && m_wen;
                e_raddr1 = int'(ibus.in_rs1);
                e_raddr2 = int'(ibus.in_rs2);
                m_busy   = 1; m_age = 0; e_ready = 0;
            end
        end else begin
            m_age++;
            if (m_age == 2) begin
                if (m_op != 0) begin
                    e_result = m_res; e_zero = (m_res == 0); e_carry = m_cy;
                end
                e_we = m_wen;
                if (m_wen) begin e_waddr = m_rd; e_wdata = m_res; end
                e_done = !m_verify;
            end else if (m_age == 3) begin
                e_we  = 0;
                m_mis = 0;
                if (m_wen) begin
                    if (drop_r6 && m_rd == 6) m_mis = (model_rf[6] != m_res);
                    else model_rf[m_rd] = m_res;
                end
                e_done = m_verify;
                if (m_verify) e_raddr1 = m_rd;
                else begin m_busy = 0; e_ready = 1; end
            end else if (m_age == 4) begin
                e_done = 0;
                if (m_mis) e_wb_err = 1;
                m_busy = 0; e_ready = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("in_ready", 32'(ibus.in_ready), 32'(e_ready));
            chk("write_enable", 32'(rbus.rf_write_enable), 32'(e_we));
            if (e_we) begin
                chk("write_addr", 32'(rbus.rf_write_addr), 32'(e_waddr));
                chk("write_data", 32'(rbus.rf_write_data), 32'(e_wdata));
            end
            chk("done", 32'(done), 32'(e_done));
            chk("result", 32'(result), 32'(e_result));
            chk("zero", 32'(zero), 32'(e_zero));
            chk("carry", 32'(carry), 32'(e_carry));
            chk("wb_err", 32'(wb_err), 32'(e_wb_err));
            chk("read_addr1", 32'(rbus.rf_read_addr1), 32'(e_raddr1));
            chk("read_addr2", 32'(rbus.rf_read_addr2), 32'(e_raddr2));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int op, input int rd, input int rs1, input int rs2, input int imm);
        ibus.in_op  = 3'(op);
        ibus.in_rd  = 3'(rd);
        ibus.in_rs1 = 3'(rs1);
        ibus.in_rs2 = 3'(rs2);
        ibus.in_imm = 8'(imm);
    endtask

    // Issue one instruction, wait for done, then one more edge so the write lands
    task automatic run_op(input int op, input int rd, input int rs1, input int rs2,
                          input int imm, output int lat, output int wr);
        int w0, k;
        lat = -1; wr = -1;
        @(negedge clk);
        drive(op, rd, rs1, rs2, imm);
        ibus.in_valid = 1'b1;
        k = 0;
        while (!ibus.in_ready && k < 20) begin @(negedge clk); k++; end
        if (!ibus.in_ready) begin
            fail_now("accept_timeout");
            ibus.in_valid = 1'b0;
            return;
        end
        w0 = n_writes;
        @(posedge clk);
        #1 ibus.in_valid = 1'b0;
        k = 0;
        while (k < 10) begin
            @(posedge clk); #1; k++;
            if (done) break;
        end
        if (!done) begin fail_now("done_timeout"); return; end
        lat = k;
        @(posedge clk); #1;
        wr = n_writes - w0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at t=%0t", $time);
        $fatal(1, "simulation bound exceeded");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat, wr, last, k, w0;
        ibus.in_valid = 1'b0;
        drive(0, 0, 0, 0, 0);

        #2 reset = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("rst_in_ready", 32'(ibus.in_ready), 32'd1);
        chk("rst_we", 32'(rbus.rf_write_enable), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_wb_err", 32'(wb_err), 32'd0);
        chk("rst_raddr1", 32'(rbus.rf_read_addr1), 32'd0);
        chk("rst_waddr", 32'(rbus.rf_write_addr), 32'd0);
        chk("rst_wdata", 32'(rbus.rf_write_data), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // LI r1 = 0x7F
        run_op(6, 1, 0, 0, 8'h7F, lat, wr);
        chk("li_r1_latency", 32'(lat), 32'(DONE_W));
        chk("li_r1_writes", 32'(wr), 32'd1);
        chk("li_r1_waddr", 32'(last_waddr), 32'd1);
        chk("li_r1_wdata", 32'(last_wdata), 32'h7F);
        chk("li_r1_result", 32'(result), 32'h7F);
        chk("li_r1_zero", 32'(zero), 32'd0);
        chk("li_r1_carry", 32'(carry), 32'd0);

        // LI r2 = 0x81; ADD r3 = r1 + r2 = 0x100 -> 0x00 with carry
        run_op(6, 2, 0, 0, 8'h81, lat, wr);
        run_op(1, 3, 1, 2, 0, lat, wr);
        chk("add_latency", 32'(lat), 32'(DONE_W));
        chk("add_waddr", 32'(last_waddr), 32'd3);
        chk("add_wdata", 32'(last_wdata), 32'h00);
        chk("add_zero", 32'(zero), 32'd1);
        chk("add_carry", 32'(carry), 32'd1);
        chk("model_r3", 32'(model_rf[3]), 32'h00);

        // SUB r4 = 0x81 - 0x7F = 0x02; SUB r5 = 0x7F - 0x81 = 0xFE with borrow
        run_op(2, 4, 2, 1, 0, lat, wr);
        chk("sub_r4_wdata", 32'(last_wdata), 32'h02);
        chk("sub_r4_carry", 32'(carry), 32'd0);
        run_op(2, 5, 1, 2, 0, lat, wr);
        chk("sub_r5_wdata", 32'(last_wdata), 32'hFE);
        chk("sub_r5_carry", 32'(carry), 32'd1);
        chk("model_r5", 32'(model_rf[5]), 32'hFE);

        // NOP: no write, result and flags unchanged
        run_op(0, 3, 1, 2, 8'h11, lat, wr);
        chk("nop_writes", 32'(wr), 32'd0);
        chk("nop_latency", 32'(lat), 32'(DONE_NW));
        chk("nop_result", 32'(result), 32'hFE);
        chk("nop_carry", 32'(carry), 32'd1);
        chk("nop_zero", 32'(zero), 32'd0);

        // LI r0: done pulses, result updates, no write strobe
        run_op(6, 0, 0, 0, 8'h55, lat, wr);
        chk("li_r0_writes", 32'(wr), 32'd0);
        chk("li_r0_latency", 32'(lat), 32'(DONE_NW));
        chk("li_r0_result", 32'(result), 32'h55);
        chk("li_r0_carry", 32'(carry), 32'd0);

        // ADDI r6 = 0x7F + 0x90 = 0x10F -> 0x0F with carry
        run_op(7, 6, 1, 3, 8'h90, lat, wr);
        chk("addi_wdata", 32'(last_wdata), 32'h0F);
        chk("addi_carry", 32'(carry), 32'd1);

        // Continuous in_valid with writing instructions
        @(negedge clk);
        ibus.in_valid = 1'b1;
        last = -1;
        for (int i = 0; i < 40; i++) begin
            if (ibus.in_ready) begin
                if (last >= 0) chk("accept_gap", 32'(cyc - last), 32'(GAP));
                last = cyc;
            end
            drive($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 255));
            @(negedge clk);
        end
        ibus.in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            ibus.in_valid = ($urandom_range(0, 9) < 7);
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 255));
        end
        @(negedge clk);
        ibus.in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Reset while an ADD r7 sits in EXEC: abandoned, no write
        k = 0;
        while (!ibus.in_ready && k < 20) begin @(negedge clk); k++; end
        drive(1, 7, 1, 2, 0);
        ibus.in_valid = 1'b1;
        @(posedge clk);
        #1 ibus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        w0 = n_writes;
        reset = 1'b1;
        #1;
        chk("exec_rst_in_ready", 32'(ibus.in_ready), 32'd1);
        chk("exec_rst_we", 32'(rbus.rf_write_enable), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("exec_rst_no_write", 32'(n_writes - w0), 32'd0);

`ifdef RF_WB_CHECK_EN
        // Read-back check: correct register file keeps wb_err low
        run_op(6, 1, 0, 0, 8'h20, lat, wr);
        run_op(6, 6, 0, 0, 8'h00, lat, wr);
        chk("verify_ok_wb_err", 32'(wb_err), 32'd0);
        chk("verify_latency", 32'(lat), 32'd3);
        // Register file drops the r6 write: ADDI r6 = 0x20 + 0x10 is never stored
        drop_r6 = 1'b1;
        run_op(7, 6, 1, 0, 8'h10, lat, wr);
        chk("verify_bad_wb_err", 32'(wb_err), 32'd1);
        drop_r6 = 1'b0;
        run_op(6, 2, 0, 0, 8'h33, lat, wr);
        chk("wb_err_sticky", 32'(wb_err), 32'd1);
`else
        run_op(6, 6, 0, 0, 8'h00, lat, wr);
        chk("no_feat_wb_err", 32'(wb_err), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
